adder_pipe_nbit: RTL and testbench

- Parametrised, pipelined successor to the combinational N-bit ripple adder.
- Splits a NUM_BITS add into NUM_STAGES equal carry-chained segments, one per clock stage.
- Provides valid/ready flow control, per-transaction signed/unsigned mode, and carry-out plus signed-overflow flags.
- Sits between operand-producing datapath logic and downstream consumers needing high-fmax wide adds.

---
 rtl/adder_pkg.sv | 21 ++
 rtl/adder_seg.sv | 38 +++
 rtl/adder_pipe_nbit.sv | 142 ++++++++++++++
 tb/tb_adder_pipe_nbit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the pipelined adder (adder_pipe_nbit).
// Holds the per-stage control record that travels with each transaction.
// Also holds the helpers that derive the segment width and judge whether a
// NUM_BITS/NUM_STAGES pairing can be split into equal segments.
package adder_pkg;

    typedef struct packed {
        logic valid;
        logic signedMode;
    } stage_ctrl_t;

    function automatic int segBits(input int numBits, input int numStages);
        return (numStages > 0) ? numBits / numStages : numBits;
    endfunction

    function automatic bit isLegal(input int numBits, input int numStages);
        return (numStages > 0) && (numBits >= 2) && (numBits >= numStages) &&
               ((numBits % numStages) == 0);
    endfunction

endpackage

// File: rtl/adder_seg.sv
// adder_seg: one registered SEG_BITS slice of the pipelined adder.
// The slice adds its operand segments and the incoming carry.
// It registers the segment sum and the carry out.
// The registers only move when i_en is high, so the whole pipe can stall.
module adder_seg #(
    parameter int SEG_BITS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                i_en,
    input  logic [SEG_BITS-1:0] i_a,
    input  logic [SEG_BITS-1:0] i_b,
    input  logic                i_cin,
    output logic [SEG_BITS-1:0] o_sum,
    output logic                o_cout
);

    logic [SEG_BITS:0]   w_full;
    logic [SEG_BITS-1:0] r_sum;
    logic                r_cout;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SEG_BITS{1'b0}}, i_cin};

    // Capture the slice result and its carry whenever the pipe advances
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (i_en) begin
            r_sum  <= w_full[SEG_BITS-1:0];
            r_cout <= w_full[SEG_BITS];
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule

// File: rtl/adder_pipe_nbit.sv
// adder_pipe_nbit: NUM_BITS adder split into NUM_STAGES carry-chained
// segments, one segment per clock, with valid/ready flow control.
// Optional build macro ADDER_PIPE_SAT_EN clamps the final sum on overflow.
// When the clamp is active, carry_out and overflow still report the raw result.
module adder_pipe_nbit #(
    parameter int NUM_BITS   = 16,
    parameter int NUM_STAGES = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    input  logic                signed_mode,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [NUM_BITS-1:0] sum,
    output logic                carry_out,
    output logic                overflow,
    output logic                out_valid,
    input  logic                out_ready
);

    import adder_pkg::*;

    localparam int SEG_BITS = segBits(NUM_BITS, NUM_STAGES);
    localparam bit LEGAL    = isLegal(NUM_BITS, NUM_STAGES);
    localparam int LAST     = NUM_STAGES - 1;

    if (!LEGAL) begin : g_illegal
        $error("adder_pipe_nbit: NUM_BITS must be a multiple of NUM_STAGES (and at least 2)");
    end

    logic                                w_advance;
    stage_ctrl_t [NUM_STAGES-1:0]        r_ctrl;
    stage_ctrl_t [NUM_STAGES-1:0]        w_ctrlIn;
    logic [NUM_STAGES-1:0][NUM_BITS-1:0] r_aPipe;
    logic [NUM_STAGES-1:0][NUM_BITS-1:0] r_bPipe;
    logic [NUM_STAGES-1:0][NUM_BITS-1:0] r_loPipe;
    logic [NUM_STAGES-1:0][NUM_BITS-1:0] w_aIn;
    logic [NUM_STAGES-1:0][NUM_BITS-1:0] w_bIn;
    logic [NUM_STAGES-1:0][NUM_BITS-1:0] w_loIn;
    logic [NUM_STAGES-1:0][NUM_BITS-1:0] w_sumVec;
    logic [NUM_STAGES-1:0]               w_cin;
    logic [SEG_BITS-1:0]                 w_segSum   [NUM_STAGES];
    logic                                w_segCarry [NUM_STAGES];
    logic [NUM_BITS-1:0]                 w_rawSum;
    logic                                w_aMsb;
    logic                                w_bMsb;
    logic                                w_overflow;
    logic                                w_unusedBits;

    assign w_advance = !r_ctrl[LAST].valid || out_ready;

    // Stage 0 sees the ports; later stages see the registers of the stage before
    always_comb begin
        w_aIn[0]               = a;
        w_bIn[0]               = b;
        w_loIn[0]              = '0;
        w_cin[0]               = carry_in;
        w_ctrlIn[0].valid      = in_valid;
        w_ctrlIn[0].signedMode = signed_mode;
        for (int k = 1; k < NUM_STAGES; k++) begin
            w_aIn[k]    = r_aPipe[k-1];
            w_bIn[k]    = r_bPipe[k-1];
            w_loIn[k]   = w_sumVec[k-1];
            w_cin[k]    = w_segCarry[k-1];
            w_ctrlIn[k] = r_ctrl[k-1];
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_seg
        adder_seg #(
            .SEG_BITS(SEG_BITS)
        ) u_seg (
            .clk    (clk),
            .n_rst  (n_rst),
            .i_en   (w_advance),
            .i_a    (w_aIn[k][k*SEG_BITS +: SEG_BITS]),
            .i_b    (w_bIn[k][k*SEG_BITS +: SEG_BITS]),
            .i_cin  (w_cin[k]),
            .o_sum  (w_segSum[k]),
            .o_cout (w_segCarry[k])
        );
    end

    // Merge each stage's fresh segment above the de-skewed lower segments it carries
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_sumVec[k] = r_loPipe[k] | (NUM_BITS'(w_segSum[k]) << (k * SEG_BITS));
        end
    end

    // Skew (operands, mode, valid) and de-skew (finished lower segments) registers move together
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_ctrl   <= '0;
            r_aPipe  <= '0;
            r_bPipe  <= '0;
            r_loPipe <= '0;
        end else if (w_advance) begin
            r_ctrl   <= w_ctrlIn;
            r_aPipe  <= w_aIn;
            r_bPipe  <= w_bIn;
            r_loPipe <= w_loIn;
        end
    end

    assign w_rawSum   = w_sumVec[LAST];
    assign w_aMsb     = r_aPipe[LAST][NUM_BITS-1];
    assign w_bMsb     = r_bPipe[LAST][NUM_BITS-1];
    assign w_overflow = r_ctrl[LAST].signedMode && (w_aMsb == w_bMsb) &&
                        (w_rawSum[NUM_BITS-1] != w_aMsb);

    // Only the operand sign bits are needed at the last stage; the rest fall out here
    assign w_unusedBits = ^{r_aPipe[LAST][NUM_BITS-2:0], r_bPipe[LAST][NUM_BITS-2:0]};

`ifdef ADDER_PIPE_SAT_EN
    localparam logic [NUM_BITS-1:0] MIN_NEG = {1'b1, {(NUM_BITS-1){1'b0}}};
    localparam logic [NUM_BITS-1:0] MAX_POS = ~MIN_NEG;

    // Clamp the aligned final result toward the side the operands were heading
    always_comb begin
        sum = w_rawSum;
        if (r_ctrl[LAST].signedMode) begin
            if (w_overflow) begin
                sum = w_aMsb ? MIN_NEG : MAX_POS;
            end
        end else if (w_segCarry[LAST]) begin
            sum = '1;
        end
    end
`else
    assign sum = w_rawSum;
`endif

    assign in_ready  = w_advance;
    assign out_valid = r_ctrl[LAST].valid;
    assign carry_out = w_segCarry[LAST];
    assign overflow  = w_overflow;

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// tb_adder_pipe_nbit: scoreboard bench for adder_pipe_nbit.
// Runs a 16-bit/4-stage instance through directed, streaming, backpressure
// and reset cases.
// Runs a 4-bit/2-stage instance through every operand combination.
module tb_adder_pipe_nbit;

    localparam int NB  = 16;
    localparam int NS  = 4;
    localparam int SNB = 4;
    localparam int SNS = 2;

    typedef struct {
        logic [15:0] sum;
        logic        carry;
        logic        ovf;
        int          due;
    } exp_t;

    logic          clk = 1'b0;
    logic          nRst = 1'b0;
    logic [NB-1:0] a = '0;
    logic [NB-1:0] b = '0;
    logic          carryIn = 1'b0;
    logic          signedMode = 1'b0;
    logic          inValid = 1'b0;
    logic          outReady = 1'b1;
    logic          inReady;
    logic [NB-1:0] sum;
    logic          carryOut;
    logic          overflow;
    logic          outValid;

    logic [SNB-1:0] sA = '0;
    logic [SNB-1:0] sB = '0;
    logic           sCin = 1'b0;
    logic           sMode = 1'b0;
    logic           sInValid = 1'b0;
    logic           sOutReady = 1'b1;
    logic           sInReady;
    logic [SNB-1:0] sSum;
    logic           sCout;
    logic           sOvf;
    logic           sOutValid;

    int   vecCount = 0;
    int   missCount = 0;
    int   cycle = 0;
    bit   latencyCheck = 1'b1;
    exp_t mainQ[$];
    exp_t smallQ[$];

    always #5 clk = ~clk;

    adder_pipe_nbit #(.NUM_BITS(NB), .NUM_STAGES(NS)) dut (
        .clk(clk), .n_rst(nRst), .a(a), .b(b), .carry_in(carryIn),
        .signed_mode(signedMode), .in_valid(inValid), .in_ready(inReady),
        .sum(sum), .carry_out(carryOut), .overflow(overflow),
        .out_valid(outValid), .out_ready(outReady)
    );

    adder_pipe_nbit #(.NUM_BITS(SNB), .NUM_STAGES(SNS)) dutSmall (
        .clk(clk), .n_rst(nRst), .a(sA), .b(sB), .carry_in(sCin),
        .signed_mode(sMode), .in_valid(sInValid), .in_ready(sInReady),
        .sum(sSum), .carry_out(sCout), .overflow(sOvf),
        .out_valid(sOutValid), .out_ready(sOutReady)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)",
                     tag, observed, expected, cycle);
        end
    endtask

    // Reference: full-width add, then flags, then optional clamp
    function automatic exp_t modelRef(input int width, input logic [15:0] av,
                                      input logic [15:0] bv, input logic cin,
                                      input logic mode);
        exp_t        e;
        logic [16:0] full;
        logic [15:0] mask;
        logic        aMsb;
        logic        bMsb;
        mask    = 16'((17'd1 << width) - 17'd1);
        full    = {1'b0, av & mask} + {1'b0, bv & mask} + 17'(cin);
        e.sum   = full[15:0] & mask;
        e.carry = full[width];
        aMsb    = av[width-1];
        bMsb    = bv[width-1];
        e.ovf   = mode && (aMsb == bMsb) && (e.sum[width-1] != aMsb);
`ifdef ADDER_PIPE_SAT_EN
        if (mode && e.ovf) e.sum = aMsb ? (16'd1 << (width-1)) : (mask >> 1);
        else if (!mode && e.carry) e.sum = mask;
`endif
        e.due = 0;
        return e;
    endfunction

    task automatic applyStimulus(input logic v, input logic [15:0] av, input logic [15:0] bv,
                                 input logic cin, input logic mode, input logic ordy);
        exp_t e;
        inValid    = v;
        a          = av;
        b          = bv;
        carryIn    = cin;
        signedMode = mode;
        outReady   = ordy;
        #1;
        if (outValid && outReady) begin
            checkOutput("main_pending", 32'(mainQ.size() != 0), 32'd1);
            if (mainQ.size() != 0) begin
                e = mainQ.pop_front();
                checkOutput("main_sum", 32'(sum), 32'(e.sum));
                checkOutput("main_cout", 32'(carryOut), 32'(e.carry));
                checkOutput("main_ovf", 32'(overflow), 32'(e.ovf));
                if (latencyCheck) checkOutput("main_latency", cycle, e.due);
            end
        end
        if (inValid && inReady) begin
            e     = modelRef(NB, av, bv, cin, mode);
            e.due = cycle + NS;
            mainQ.push_back(e);
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic applyIdle(input logic ordy);
        applyStimulus(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, ordy);
    endtask

    task automatic applySmall(input logic v, input logic [3:0] av, input logic [3:0] bv,
                              input logic cin, input logic mode);
        exp_t e;
        sInValid = v;
        sA       = av;
        sB       = bv;
        sCin     = cin;
        sMode    = mode;
        #1;
        if (sOutValid && sOutReady) begin
            checkOutput("small_pending", 32'(smallQ.size() != 0), 32'd1);
            if (smallQ.size() != 0) begin
                e = smallQ.pop_front();
                checkOutput("small_sum", 32'(sSum), 32'(e.sum));
                checkOutput("small_cout", 32'(sCout), 32'(e.carry));
                checkOutput("small_ovf", 32'(sOvf), 32'(e.ovf));
                checkOutput("small_latency", cycle, e.due);
            end
        end
        if (sInValid && sInReady) begin
            e     = modelRef(SNB, {12'd0, av}, {12'd0, bv}, cin, mode);
            e.due = cycle + SNS;
            smallQ.push_back(e);
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    initial begin
        logic [15:0] heldSum;
        logic [8:0]  combo;

        // Power-on reset
        nRst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nRst = 1'b1;
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_cout", 32'(carryOut), 32'd0);
        checkOutput("reset_ovf", 32'(overflow), 32'd0);
        checkOutput("reset_out_valid", 32'(outValid), 32'd0);
        checkOutput("reset_in_ready", 32'(inReady), 32'd1);

        // Directed corner cases: wrap, signed overflow both ways, carry across segments
        latencyCheck = 1'b1;
        applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0FFF, 16'hF000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'hFFFE, 16'hFFFF, 1'b1, 1'b1, 1'b1);
        repeat (NS + 2) applyIdle(1'b1);

        // Throughput: eight back-to-back random transactions
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        repeat (NS + 2) applyIdle(1'b1);

        // Backpressure: fill with the consumer stalled, hold, then release
        latencyCheck = 1'b0;
        for (int i = 0; i < NS; i++) begin
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
        checkOutput("bp_full_valid", 32'(outValid), 32'd1);
        heldSum = sum;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
            checkOutput("bp_in_ready", 32'(inReady), 32'd0);
            checkOutput("bp_sum_hold", 32'(sum), 32'(heldSum));
            checkOutput("bp_valid_hold", 32'(outValid), 32'd1);
        end
        for (int i = 0; i < NS; i++) begin
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        repeat (NS + 2) applyIdle(1'b1);
        checkOutput("bp_drained", 32'(mainQ.size()), 32'd0);

        // Reset with three transactions in flight
        latencyCheck = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        inValid = 1'b0;
        nRst    = 1'b0;
        @(posedge clk);
        #1;
        cycle++;
        nRst = 1'b1;
        mainQ.delete();
        checkOutput("midreset_out_valid", 32'(outValid), 32'd0);
        checkOutput("midreset_sum", 32'(sum), 32'd0);
        checkOutput("midreset_cout", 32'(carryOut), 32'd0);
        repeat (NS + 3) applyIdle(1'b1);

        // Exhaustive cross-check on the narrow instance, both modes
        inValid = 1'b0;
        for (int m = 0; m < 2; m++) begin
            for (int idx = 0; idx < 512; idx++) begin
                combo = 9'(idx);
                applySmall(1'b1, combo[3:0], combo[7:4], combo[8], 1'(m));
            end
        end
        repeat (SNS + 2) applySmall(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        checkOutput("small_drained", 32'(smallQ.size()), 32'd0);
        checkOutput("main_drained", 32'(mainQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
